key_extract: RTL and testbench

KEY_EXTRACT -- requirements
Module: key_extract

---
 rtl/key_extract_pkg.sv | 57 +++++
 rtl/key_extract_slot_mux.sv | 25 ++
 rtl/key_extract.sv | 137 +++++++++++++
 tb/tb_key_extract.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_extract_pkg.sv
// Shared constants and payload types for the key-extraction stage.
package key_extract_pkg;

  // PHV geometry
  localparam int unsigned PHV_W     = 1124;
  localparam int unsigned N_CONT    = 8;
  localparam int unsigned C48_W     = 48;
  localparam int unsigned C32_W     = 32;
  localparam int unsigned C16_W     = 16;
  localparam int unsigned C48_LSB   = 740;
  localparam int unsigned C32_LSB   = 484;
  localparam int unsigned C16_LSB   = 356;
  localparam int unsigned F20_LSB   = 256;
  localparam int unsigned IDX_LSB   = 252;
  localparam int unsigned FLAGS_W   = 5;

  // Key-config table geometry
  localparam int unsigned CFG_BITS  = 24;
  localparam int unsigned CFG_DEPTH = 16;
  localparam int unsigned CFG_AW    = 4;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned EN_W      = 6;

  // Slot enable bit positions inside cfg_t.en
  localparam int unsigned EN_48A    = 5;
  localparam int unsigned EN_48B    = 4;
  localparam int unsigned EN_32A    = 3;
  localparam int unsigned EN_32B    = 2;
  localparam int unsigned EN_16A    = 1;
  localparam int unsigned EN_16B    = 0;

  // Match key width: two slots per container class plus flags
  localparam int unsigned KEY_W     = 2 * (C48_W + C32_W + C16_W) + FLAGS_W;

  // Key-config entry; field order fixes the bit positions ([23:21] = sel48_a ... [5:0] = en)
  typedef struct packed {
    logic [SEL_W-1:0] sel48_a;
    logic [SEL_W-1:0] sel48_b;
    logic [SEL_W-1:0] sel32_a;
    logic [SEL_W-1:0] sel32_b;
    logic [SEL_W-1:0] sel16_a;
    logic [SEL_W-1:0] sel16_b;
    logic [EN_W-1:0]  en;
  } cfg_t;

  // Match key as presented to the lookup stage (MSB first)
  typedef struct packed {
    logic [C48_W-1:0]   k48_a;
    logic [C48_W-1:0]   k48_b;
    logic [C32_W-1:0]   k32_a;
    logic [C32_W-1:0]   k32_b;
    logic [C16_W-1:0]   k16_a;
    logic [C16_W-1:0]   k16_b;
    logic [FLAGS_W-1:0] flags;
  } key_t;

endpackage

// File: rtl/key_extract_slot_mux.sv
// One key slot: picks one of eight same-width containers, or zero when disabled.
module key_slot_mux
  import key_extract_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [N_CONT*W-1:0] containers,
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [W-1:0]        slot_c
);

  // Container select with enable gating
  always_comb begin
    slot_c = '0;
    if (en) begin
      for (int i = 0; i < int'(N_CONT); i++) begin
        if (sel == SEL_W'(i)) begin
          slot_c = containers[i*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/key_extract.sv
// Key extraction: looks up a per-PHV key config, builds the match key in a
// two-stage valid/ready pipeline and forwards the PHV alongside it.
module key_extract
  import key_extract_pkg::*;
#(
  parameter int          STAGE   = 0,
  parameter int unsigned PHV_LEN = PHV_W,
  parameter int unsigned KEY_LEN = KEY_W,
  parameter int unsigned CFG_W   = CFG_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic               phv_ready_out,
  output logic [KEY_LEN-1:0] extract_key,
  output logic               key_valid,
  input  logic               key_ready_in,
  output logic [PHV_LEN-1:0] phv_out,
  input  logic               cfg_wr_en,
  input  logic [3:0]         cfg_wr_addr,
  input  logic [CFG_W-1:0]   cfg_wr_data
);

  // The field layout is fixed by the package; reject any other sizing at elaboration
  if (PHV_LEN != PHV_W || KEY_LEN != KEY_W || CFG_W != CFG_BITS || STAGE < 0) begin : g_param_check
    $error("key_extract: unsupported parameterisation");
  end

  cfg_t               cfg_mem [CFG_DEPTH];
  logic [CFG_AW-1:0]  cfg_idx_c;

  logic               s1_valid;
  logic [PHV_LEN-1:0] s1_phv;
  cfg_t               s1_cfg;
  logic               s1_adv_c;

  logic [C48_W-1:0]   slot_48a_c;
  logic [C48_W-1:0]   slot_48b_c;
  logic [C32_W-1:0]   slot_32a_c;
  logic [C32_W-1:0]   slot_32b_c;
  logic [C16_W-1:0]   slot_16a_c;
  logic [C16_W-1:0]   slot_16b_c;
  key_t               key_c;

  assign cfg_idx_c     = phv_in[IDX_LSB +: CFG_AW];
  assign s1_adv_c      = !key_valid || key_ready_in;
  assign phv_ready_out = !s1_valid || s1_adv_c;

  // Config table: writes land at the edge, so a same-edge S1 read sees the old entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CFG_DEPTH); i++) begin
        cfg_mem[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      cfg_mem[cfg_wr_addr] <= cfg_t'(cfg_wr_data);
    end
  end

  // S1: capture the PHV and its config entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phv   <= '0;
      s1_cfg   <= '0;
    end else if (phv_ready_out) begin
      s1_valid <= phv_valid_in;
      if (phv_valid_in) begin
        s1_phv <= phv_in;
        s1_cfg <= cfg_mem[cfg_idx_c];
      end
    end
  end

  key_slot_mux #(.W(C48_W)) u_slot_48a (
    .containers (s1_phv[C48_LSB +: N_CONT*C48_W]),
    .sel        (s1_cfg.sel48_a),
    .en         (s1_cfg.en[EN_48A]),
    .slot_c     (slot_48a_c)
  );

  key_slot_mux #(.W(C48_W)) u_slot_48b (
    .containers (s1_phv[C48_LSB +: N_CONT*C48_W]),
    .sel        (s1_cfg.sel48_b),
    .en         (s1_cfg.en[EN_48B]),
    .slot_c     (slot_48b_c)
  );

  key_slot_mux #(.W(C32_W)) u_slot_32a (
    .containers (s1_phv[C32_LSB +: N_CONT*C32_W]),
    .sel        (s1_cfg.sel32_a),
    .en         (s1_cfg.en[EN_32A]),
    .slot_c     (slot_32a_c)
  );

  key_slot_mux #(.W(C32_W)) u_slot_32b (
    .containers (s1_phv[C32_LSB +: N_CONT*C32_W]),
    .sel        (s1_cfg.sel32_b),
    .en         (s1_cfg.en[EN_32B]),
    .slot_c     (slot_32b_c)
  );

  key_slot_mux #(.W(C16_W)) u_slot_16a (
    .containers (s1_phv[C16_LSB +: N_CONT*C16_W]),
    .sel        (s1_cfg.sel16_a),
    .en         (s1_cfg.en[EN_16A]),
    .slot_c     (slot_16a_c)
  );

  key_slot_mux #(.W(C16_W)) u_slot_16b (
    .containers (s1_phv[C16_LSB +: N_CONT*C16_W]),
    .sel        (s1_cfg.sel16_b),
    .en         (s1_cfg.en[EN_16B]),
    .slot_c     (slot_16b_c)
  );

  // Flags ride along unmasked in the low bits
  assign key_c = {slot_48a_c, slot_48b_c, slot_32a_c, slot_32b_c,
                  slot_16a_c, slot_16b_c, s1_phv[FLAGS_W-1:0]};

  // S2: output register; holds while stalled by the lookup stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid   <= 1'b0;
      extract_key <= '0;
      phv_out     <= '0;
    end else if (s1_adv_c) begin
      key_valid <= s1_valid;
      if (s1_valid) begin
        extract_key <= KEY_LEN'(key_c);
        phv_out     <= s1_phv;
      end
    end
  end

endmodule

// File: tb/tb_key_extract.sv
// Scoreboard bench for key_extract: driver predicts keys from a config-table
// model, monitor compares every presented output against the queue head.
module tb_key_extract;

  localparam int PL = 1124;
  localparam int KL = 197;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [PL-1:0] phv_in;
  logic          phv_valid_in;
  logic          phv_ready_out;
  logic [KL-1:0] extract_key;
  logic          key_valid;
  logic          key_ready_in;
  logic [PL-1:0] phv_out;
  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_addr;
  logic [CW-1:0] cfg_wr_data;

  typedef struct {
    logic [KL-1:0] key;
    logic [PL-1:0] phv;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] mcfg [16];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            front_seen = 0;

  key_extract dut (
    .clk           (clk),
    .rst           (rst),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .phv_ready_out (phv_ready_out),
    .extract_key   (extract_key),
    .key_valid     (key_valid),
    .key_ready_in  (key_ready_in),
    .phv_out       (phv_out),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: pick containers by plain shifting of the PHV
  function automatic logic [KL-1:0] model_key(input logic [PL-1:0] p, input logic [CW-1:0] c);
    logic [PL-1:0] t;
    logic [47:0] a48, b48;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    t = p >> (740 + 48 * c[23:21]); a48 = t[47:0];
    t = p >> (740 + 48 * c[20:18]); b48 = t[47:0];
    t = p >> (484 + 32 * c[17:15]); a32 = t[31:0];
    t = p >> (484 + 32 * c[14:12]); b32 = t[31:0];
    t = p >> (356 + 16 * c[11:9]);  a16 = t[15:0];
    t = p >> (356 + 16 * c[8:6]);   b16 = t[15:0];
    if (!c[5]) a48 = '0;
    if (!c[4]) b48 = '0;
    if (!c[3]) a32 = '0;
    if (!c[2]) b32 = '0;
    if (!c[1]) a16 = '0;
    if (!c[0]) b16 = '0;
    return {a48, b48, a32, b32, a16, b16, p[4:0]};
  endfunction

  function automatic logic [PL-1:0] rand_phv(input logic [3:0] idx);
    logic [1151:0] w;
    logic [PL-1:0] r;
    for (int i = 0; i < 36; i++) w[i*32 +: 32] = $urandom();
    r = w[PL-1:0];
    r[255:252] = idx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_phv(input string name, input logic [PL-1:0] got, input logic [PL-1:0] exp);
    logic [1151:0] g, e;
    int lo;
    checks++;
    if (got !== exp) begin
      errors++;
      g = {28'd0, got};
      e = {28'd0, exp};
      lo = 0;
      for (int i = PL - 1; i >= 0; i--) if (got[i] !== exp[i]) lo = (i / 64) * 64;
      $display("FAIL %s: bits [%0d+:64] got %h expected %h", name, lo, g[lo +: 64], e[lo +: 64]);
    end
  endtask

  // One input cycle; records the prediction when the PHV is accepted
  task automatic drive_cycle(input bit v, input logic [PL-1:0] p, input bit krdy,
                             input bit we, input logic [3:0] wa, input logic [CW-1:0] wd,
                             input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    phv_valid_in = v;
    phv_in       = p;
    key_ready_in = krdy;
    cfg_wr_en    = we;
    cfg_wr_addr  = wa;
    cfg_wr_data  = wd;
    #1;
    acc = v && phv_ready_out;
    if (acc) begin
      e.key = model_key(p, mcfg[p[255:252]]);
      e.phv = p;
      e.cyc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
    if (we) mcfg[wa] = wd;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive_cycle(0, '0, 1, 0, 4'd0, '0, 0, acc);
  endtask

  // Monitor: compare the presented output with the queue head every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got key %h expected no output", extract_key);
        end else begin
          e = exp_q[0];
          chk("key", 256'(extract_key), 256'(e.key));
          chk_phv("phv_out", phv_out, e.phv);
          if (!front_seen) begin
            front_seen = 1;
            if (e.lat) chk("latency", 256'(cyc - e.cyc), 256'(2));
          end
          if (key_ready_in) begin
            void'(exp_q.pop_front());
            front_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    logic [PL-1:0] p, p1, p2;
    logic [PL-1:0] ps [3];
    logic [CW-1:0] w;
    int            k, n;

    for (int i = 0; i < 16; i++) mcfg[i] = '0;
    rst = 1'b1;
    phv_valid_in = 0; phv_in = '0; key_ready_in = 0;
    cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_key_valid", 256'(key_valid), 256'(0));
    chk("rst_extract_key", 256'(extract_key), 256'(0));
    chk_phv("rst_phv_out", phv_out, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 256'(phv_ready_out), 256'(1));

    // Full-select entry 3, 48A picks C6_7
    drive_cycle(0, '0, 1, 1, 4'd3, 24'hFFFFFF, 0, acc);
    p = rand_phv(4'd3);
    p[1123:1076] = 48'hAAAA_BBBB_CCCC;
    p[4:0] = 5'h15;
    drive_cycle(1, p, 1, 0, 4'd0, '0, 1, acc);
    chk("accept_first", 256'(acc), 256'(1));
    idle(1);
    chk("early_key_valid", 256'(key_valid), 256'(0));
    idle(1);
    chk("dir_key_valid", 256'(key_valid), 256'(1));
    chk("dir_48a", 256'(extract_key[196:149]), 256'(48'hAAAA_BBBB_CCCC));
    chk("dir_flags", 256'(extract_key[4:0]), 256'(5'h15));
    chk_phv("dir_phv_out", phv_out, p);

    // All slots disabled: only flags survive
    w = 24'($urandom()) & 24'hFFFFC0;
    drive_cycle(0, '0, 1, 1, 4'd7, w, 0, acc);
    p = rand_phv(4'd7);
    drive_cycle(1, p, 1, 0, 4'd0, '0, 1, acc);
    idle(2);
    chk("zero_key_valid", 256'(key_valid), 256'(1));
    chk("zero_slots", 256'(extract_key[196:5]), 256'(0));
    chk("zero_flags", 256'(extract_key[4:0]), 256'(p[4:0]));

    // Random configs, then eight back-to-back PHVs
    for (int i = 0; i < 16; i++) drive_cycle(0, '0, 1, 1, 4'(i), 24'($urandom()), 0, acc);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1, rand_phv(4'($urandom_range(0, 15))), 1, 0, 4'd0, '0, 1, acc);
      if (acc) n++;
    end
    chk("b2b_accepts", 256'(n), 256'(8));
    idle(3);

    // Backpressure: three offered while the lookup stage stalls for five cycles
    for (int i = 0; i < 3; i++) ps[i] = rand_phv(4'($urandom_range(0, 15)));
    k = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(k < 3, ps[k < 3 ? k : 2], 0, 0, 4'd0, '0, 0, acc);
      if (acc) k++;
    end
    chk("stall_accepts", 256'(k), 256'(2));
    chk("stall_ready", 256'(phv_ready_out), 256'(0));
    n = 0;
    while (k < 3 && n < 10) begin
      drive_cycle(1, ps[k], 1, 0, 4'd0, '0, 0, acc);
      if (acc) k++;
      n++;
    end
    chk("stall_release", 256'(k), 256'(3));
    idle(4);

    // Same-edge config write vs S1 read of entry 5
    drive_cycle(0, '0, 1, 1, 4'd5, 24'h00003F, 0, acc);
    p1 = rand_phv(4'd5);
    drive_cycle(1, p1, 1, 1, 4'd5, 24'hFFFFFF, 1, acc);
    p2 = rand_phv(4'd5);
    drive_cycle(1, p2, 1, 0, 4'd0, '0, 1, acc);
    idle(3);

    // Random traffic with backpressure and config writes
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, rand_phv(4'($urandom_range(0, 15))),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), 24'($urandom()), 0, acc);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain_empty", 256'(exp_q.size()), 256'(0));

    // Reset with two PHVs in flight
    drive_cycle(1, rand_phv(4'd2), 0, 0, 4'd0, '0, 0, acc);
    drive_cycle(1, rand_phv(4'd9), 0, 0, 4'd0, '0, 0, acc);
    @(negedge clk);
    phv_valid_in = 0;
    rst = 1'b1;
    #1;
    chk("midrst_key_valid", 256'(key_valid), 256'(0));
    chk("midrst_extract_key", 256'(extract_key), 256'(0));
    chk_phv("midrst_phv_out", phv_out, '0);
    exp_q.delete();
    front_seen = 0;
    for (int i = 0; i < 16; i++) mcfg[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("post_rst_quiet", 256'(key_valid), 256'(0));
    end
    chk("post_rst_ready", 256'(phv_ready_out), 256'(1));
    drive_cycle(1, rand_phv(4'($urandom_range(0, 15))), 1, 0, 4'd0, '0, 1, acc);
    idle(4);
    chk("final_empty", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
